btn_debouncer: RTL and testbench

//   Conditions the raw, active-high push-button inputs (inverted KEY[2:0]) before the core's
//   btn bus. Per channel: 2-FF synchronizer, stability-counter debounce FSM, clean level,
//   1-cycle press/release pulses. Sits between board pins and top.btn; one instance per board top.

---
 rtl/btn_debouncer_pkg.sv | 10 +
 rtl/btn_debouncer_if.sv | 14 +
 rtl/btn_debounce_channel.sv | 103 ++++++++++
 rtl/btn_debouncer.sv | 27 ++
 tb/tb_btn_debouncer.sv | 122 ++++++++++++
 5 files changed

// File: rtl/btn_debouncer_pkg.sv
// btn_debouncer_pkg: debounce FSM states, default timing constants and counter width helper
package btn_debouncer_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;
  localparam int DEF_N_BTN = 3;
  localparam int DEF_STABLE_CYCLES = 500_000;
  localparam int DEF_LONG_CYCLES = 50_000_000;
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/btn_debouncer_if.sv
// btn_debouncer_if: raw button inputs and conditioned level/pulse outputs
interface btn_debouncer_if
  import btn_debouncer_pkg::*;
#(
  parameter int N_BTN = DEF_N_BTN
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  modport master (output btn_raw, input btn_level, input btn_press, input btn_release, input btn_long);
  modport slave (input btn_raw, output btn_level, output btn_press, output btn_release, output btn_long);
endinterface

// File: rtl/btn_debounce_channel.sv
// btn_debounce_channel: one button (2-FF sync, stability FSM, pulses; long press with BTN_DEBOUNCER_LONG_PRESS_EN)
module btn_debounce_channel
  import btn_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);
  localparam int CNT_WIDTH = cnt_width(STABLE_CYCLES, LONG_CYCLES);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  logic [1:0] sync_q;
  logic s;
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic level_q, level_d, press_q, press_d, rel_q, rel_d;
  assign s = sync_q[1];
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q <= rel_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d = 1'b0;
    case (state_q)
      IDLE: if (s) begin
        state_d = PRESS_WAIT;
        cnt_d = CNT_WIDTH'(1);
      end
      PRESS_WAIT: if (!s) begin
        state_d = IDLE;
        cnt_d = '0;
      end else if (cnt_q == STABLE_LAST) begin
        state_d = PRESSED;
        level_d = 1'b1;
        press_d = 1'b1;
      end else cnt_d = cnt_inc;
      PRESSED: if (!s) begin
        state_d = RELEASE_WAIT;
        cnt_d = CNT_WIDTH'(1);
      end
      RELEASE_WAIT: if (s) begin
        state_d = PRESSED;
        cnt_d = '0;
      end else if (cnt_q == STABLE_LAST) begin
        state_d = IDLE;
        level_d = 1'b0;
        rel_d = 1'b1;
      end else cnt_d = cnt_inc;
      default: state_d = IDLE;
    endcase
  end
  assign level_o = level_q;
  assign press_o = press_q;
  assign release_o = rel_q;
`ifdef BTN_DEBOUNCER_LONG_PRESS_EN
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic long_q, long_d;
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if ((state_q == PRESS_WAIT && state_d == PRESSED) || (state_q == RELEASE_WAIT && state_d == IDLE)) hold_d = '0;
    else if (state_q == PRESSED && s) begin
      long_d = hold_q == LONG_LAST;
      hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif
endmodule

// File: rtl/btn_debouncer.sv
// btn_debouncer: N_BTN independent debounce channels (long-press pulse with BTN_DEBOUNCER_LONG_PRESS_EN)
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int N_BTN = DEF_N_BTN,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input logic clk,
  input logic rst,
  btn_debouncer_if.slave bus
);
  for (genvar c = 0; c < N_BTN; c++) begin : g_ch
    btn_debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .raw_i(bus.btn_raw[c]),
      .level_o(bus.btn_level[c]),
      .press_o(bus.btn_press[c]),
      .release_o(bus.btn_release[c]),
      .long_o(bus.btn_long[c])
    );
  end
endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: randomized and directed stimulus, reference model scoreboard checked every cycle
module tb_btn_debouncer;
  localparam int N = 3;
  localparam int STABLE = 4;
  localparam int LONG = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passes = 0;
  logic [4*N-1:0] exp_q[$];
  logic [N-1:0] rq[$];
  logic [N-1:0] sq[$];
  logic [N-1:0] lvl_m = '0;
  int hold_m[N];
  btn_debouncer_if #(.N_BTN(N)) bus ();
  btn_debouncer #(
    .N_BTN(N),
    .STABLE_CYCLES(STABLE),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    logic [N-1:0] s, s_prev, prs, rel, lng;
    int differ;
    if (rst) begin
      rq.delete();
      sq.delete();
      lvl_m = '0;
      for (int c = 0; c < N; c++) hold_m[c] = 0;
      exp_q.push_back('0);
    end else begin
      s = (rq.size() >= 2) ? rq[rq.size()-2] : '0;
      s_prev = (sq.size() > 0) ? sq[sq.size()-1] : '0;
      rq.push_back(bus.btn_raw);
      sq.push_back(s);
      if (rq.size() > 2) void'(rq.pop_front());
      if (sq.size() > STABLE) void'(sq.pop_front());
      prs = '0;
      rel = '0;
      lng = '0;
      for (int c = 0; c < N; c++) begin
        differ = 0;
        foreach (sq[k]) if (sq[k][c] != lvl_m[c]) differ++;
        if (differ == STABLE) begin
          prs[c] = !lvl_m[c];
          rel[c] = lvl_m[c];
          lvl_m[c] = !lvl_m[c];
          hold_m[c] = 0;
        end else if (lvl_m[c] && s[c] && s_prev[c]) begin
          lng[c] = (hold_m[c] == LONG - 1);
          hold_m[c]++;
        end
      end
`ifndef BTN_DEBOUNCER_LONG_PRESS_EN
      lng = '0;
`endif
      exp_q.push_back({lvl_m, prs, rel, lng});
    end
  end
  initial begin
    logic [4*N-1:0] got, exp;
    @(posedge clk);
    forever begin
      @(negedge clk);
      got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long};
      checks++;
      if (exp_q.size() == 0) $display("FAIL scoreboard_empty t=%0t dut=%b", $time, got);
      else begin
        exp = exp_q.pop_front();
        if (rst) exp = '0;
        if (got === exp) passes++;
        else $display("FAIL outputs t=%0t dut lvl/prs/rel/lng=%b required=%b", $time, got, exp);
      end
    end
  end
  task automatic hold(input logic [N-1:0] v, input int n);
    bus.btn_raw = v;
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic pulse_rst(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask
  initial begin
    bus.btn_raw = 3'b111;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    hold(3'b111, 10);
    hold(3'b000, 10);
    hold(3'b001, 10);
    hold(3'b000, 10);
    hold(3'b010, 1);
    hold(3'b000, 1);
    hold(3'b010, 1);
    hold(3'b000, 1);
    hold(3'b010, 10);
    hold(3'b000, 10);
    hold(3'b100, 10);
    hold(3'b000, 2);
    hold(3'b100, 10);
    hold(3'b000, 10);
    hold(3'b001, 4);
    pulse_rst(2);
    hold(3'b001, 25);
    hold(3'b000, 10);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 30) == 0) pulse_rst($urandom_range(1, 2));
      hold(N'($urandom_range(0, 7)), $urandom_range(1, 8));
    end
    hold(3'b000, 10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
